mem_ready_sched: RTL and testbench
==================================

Name: mem_ready_sched

Overview:
- Memory-side handshake controller for the picorv32 native memory port in formal and simulation testbenches.
- Accepts a core request (mem_valid) and holds it for a bounded, externally chosen number of wait states. Then pulses mem_ready for one cycle.
- Monitors the request for protocol violations while it is held, and reports them on a sticky error flag with a code.
- Counts completed transactions.

Parameters:
- WAIT_W, 3, width of the wait_req input.
- MAX_WAIT, 5, upper bound on wait states per transaction; wait_req is clamped to this value.
- CNT_W, 16, width of the saturating txn_count output.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_valid  input  1  core request valid.
- mem_instr  input  1  request is an instruction fetch.
- mem_addr  input  32  request address.
- mem_wdata  input  32  write data.
- mem_wstrb  input  4  byte write strobes; 0 means read.
- wait_req  input  WAIT_W  wait states requested for the next accepted transaction. Free input, nondeterministic in formal.
- mem_ready  output  1  registered one-cycle completion pulse to the core.
- busy  output  1  high while in WAIT or READY state.
- protocol_err  output  1  sticky violation flag.
- err_code  output  2  code of the first violation: 0 none, 1 valid dropped, 2 payload changed, 3 illegal wstrb or misaligned address.
- txn_count  output  CNT_W  completed transactions, saturating.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state=IDLE.
  - mem_ready=0, busy=0, protocol_err=0, err_code=0, txn_count=0.
  - Latched payload cleared.
- States: IDLE, WAIT, READY.
- IDLE:
  - On mem_valid=1: latch instr/addr/wdata/wstrb.
  - Load wait counter with min(wait_req, MAX_WAIT).
  - Next state is WAIT if the loaded value is >0, else READY.
  - Otherwise stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1 (the final wait cycle), next state is READY.
  - Net timing: N wait states give mem_ready high exactly N+1 cycles after the first cycle mem_valid is seen in IDLE.
- READY:
  - mem_ready=1 for exactly this one cycle.
  - txn_count increments, saturating at all-ones.
  - Next state is IDLE unconditionally.
- A mem_valid still high in the IDLE cycle after READY is treated as a new request.
- Monitor, active in WAIT and READY:
  - mem_valid=0 gives code 1.
  - Any change in instr, addr or wstrb versus the latched values gives code 2.
  - A change in wdata gives code 2 only when the latched wstrb is nonzero.
  - The transaction still completes on schedule after an error.
- Legality check, evaluated in IDLE on acceptance:
  - Code 3 if mem_addr[1:0] != 0.
  - Code 3 if wstrb is not one of 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Error priority and latching:
  - Simultaneous violations in one cycle: lowest nonzero code wins.
  - The first error is latched. protocol_err and err_code hold until reset; later errors are ignored.
- busy = (state != IDLE).
- mem_ready is driven only from state, with no combinational path from inputs.

Decomposition:
- Shared package mem_sched_pkg:
  - state enum {IDLE, WAIT, READY}.
  - err_code enum.
  - MAX_WAIT default constant.
  - pure function wstrb_legal(logic[3:0]).
- One sub-module: mem_req_monitor.
  - Contains the payload latch, stability compare, legality check and sticky error register.
  - Takes latch-enable and check-enable inputs from the state machine.
- The top level holds the state machine, wait counter and txn counter.

Test Plan:
1. Read, addr=0x100, wstrb=0, wait_req=0; mem_valid held until ready -> mem_ready high 1 cycle after valid; txn_count=1; protocol_err=0.
2. Write, addr=0x204, wstrb=1111, wait_req=3 -> mem_ready exactly 4 cycles after valid, high 1 cycle; busy high for 4 cycles.
3. wait_req=7 with MAX_WAIT=5 -> clamped; mem_ready 6 cycles after valid.
4. Read held 2 wait states, mem_addr changes 0x100->0x104 in WAIT -> protocol_err=1, err_code=2 next cycle; mem_ready still on schedule. A later mem_valid drop leaves err_code=2.
5. Accept with wstrb=0101, addr=0x102 -> err_code=3. Separately, mem_valid dropped mid-WAIT -> err_code=1.
6. Reset asserted in WAIT with wait_req=5 -> mem_ready, busy and counters go to 0 immediately with no clock edge. After release, IDLE accepts a new request normally.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - shared types and helpers for the memory ready scheduler
package mem_sched_pkg;

  localparam int MAX_WAIT_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_VALID_DROP = 2'd1,
    ERR_PAYLOAD    = 2'd2,
    ERR_ILLEGAL    = 2'd3
  } err_code_e;

  // Byte, aligned halfword and full word strobes only.
  function automatic logic wstrb_legal(input logic [3:0] wstrb);
    case (wstrb)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_ready_sched_if.sv
// rtl/mem_ready_sched_if.sv - picorv32 native memory port bundle
interface mem_ready_sched_if;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready
  );

endinterface

// File: rtl/mem_req_monitor.sv
// rtl/mem_req_monitor.sv - payload latch, stability/legality checks and sticky error
module mem_req_monitor
  import mem_sched_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        latch_en,
  input  logic        check_en,
  input  logic        valid,
  input  logic        instr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        protocol_err,
  output logic [1:0]  err_code
);

  logic        instr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        err_q;
  err_code_e   code_q;
  err_code_e   cur_code;

  // Codes are tested lowest first so the lowest violation wins a tie.
  always_comb begin
    cur_code = ERR_NONE;
    if (latch_en) begin
      if (addr[1:0] != 2'b00 || !wstrb_legal(wstrb))
        cur_code = ERR_ILLEGAL;
    end else if (check_en) begin
      if (!valid)
        cur_code = ERR_VALID_DROP;
      else if (instr != instr_q || addr != addr_q || wstrb != wstrb_q ||
               (wstrb_q != 4'b0000 && wdata != wdata_q))
        cur_code = ERR_PAYLOAD;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      if (latch_en) begin
        instr_q <= instr;
        addr_q  <= addr;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (!err_q && cur_code != ERR_NONE) begin
        err_q  <= 1'b1;
        code_q <= cur_code;
      end
    end
  end

  assign protocol_err = err_q;
  assign err_code     = code_q;

endmodule

// File: rtl/mem_ready_sched.sv
// rtl/mem_ready_sched.sv - memory-side wait-state scheduler for the picorv32 native port
module mem_ready_sched
  import mem_sched_pkg::*;
#(
  parameter int WAIT_W   = 3,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  mem_ready_sched_if.slave  bus,
  input  logic [WAIT_W-1:0] wait_req,
  output logic              busy,
  output logic              protocol_err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  txn_count
);

  localparam logic [WAIT_W-1:0] WAIT_CAP = WAIT_W'(MAX_WAIT);

  state_e            state;
  state_e            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic [WAIT_W-1:0] wait_clamped;
  logic              accept;

  assign wait_clamped = (wait_req > WAIT_CAP) ? WAIT_CAP : wait_req;
  assign accept       = (state == IDLE) && bus.mem_valid;

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
        if (bus.mem_valid) begin
          wait_cnt_next = wait_clamped;
          state_next    = (wait_clamped != '0) ? WAIT : READY;
        end
      end
      WAIT: begin
        wait_cnt_next = wait_cnt - WAIT_W'(1);
        if (wait_cnt == WAIT_W'(1))
          state_next = READY;
      end
      READY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      txn_count <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state == READY && txn_count != '1)
        txn_count <= txn_count + CNT_W'(1);
    end
  end

  // Outputs decode the state register only, keeping inputs off the ready path.
  assign bus.mem_ready = (state == READY);
  assign busy          = (state != IDLE);

  mem_req_monitor u_monitor (
    .clock        (clock),
    .reset        (reset),
    .latch_en     (accept),
    .check_en     (busy),
    .valid        (bus.mem_valid),
    .instr        (bus.mem_instr),
    .addr         (bus.mem_addr),
    .wdata        (bus.mem_wdata),
    .wstrb        (bus.mem_wstrb),
    .protocol_err (protocol_err),
    .err_code     (err_code)
  );

endmodule

// File: tb/tb_mem_ready_sched.sv
// tb/tb_mem_ready_sched.sv - scoreboard bench for mem_ready_sched
module tb_mem_ready_sched;

  localparam int CNT_W   = 5;
  localparam int MAXW    = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       wait_req = 3'd0;
  logic             busy;
  logic             protocol_err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] txn_count;

  mem_ready_sched_if bus();

  mem_ready_sched #(.WAIT_W(3), .MAX_WAIT(MAXW), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .wait_req     (wait_req),
    .busy         (busy),
    .protocol_err (protocol_err),
    .err_code     (err_code),
    .txn_count    (txn_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int ready_cyc;
    int err;
    int code;
    int cnt;
  } exp_t;

  exp_t       sb[$];
  bit         busy_map[int];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 0;
  int         m_err, m_code, m_cnt;
  logic [3:0] legal_strb[8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
  logic [3:0] bad_strb[8]   = '{4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE};

  function automatic bit is_legal(input logic [31:0] a, input logic [3:0] s);
    bit ok = 0;
    foreach (legal_strb[i]) if (legal_strb[i] == s) ok = 1;
    return ok && (a[1:0] == 2'b00);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit v, input bit i, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    bus.mem_valid = v;
    bus.mem_instr = i;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wstrb = s;
  endtask

  task automatic run_monitor();
    exp_t it;
    bit   exp_ready;
    forever begin
      @(negedge clock);
      if (mon_en && !reset) begin
        check("busy", busy, busy_map.exists(cyc));
        exp_ready = (sb.size() > 0) && (sb[0].ready_cyc == cyc);
        check("mem_ready", bus.mem_ready, exp_ready);
        if (exp_ready) begin
          it = sb.pop_front();
          check("err_at_ready", protocol_err, it.err);
          check("code_at_ready", err_code, it.code);
          check("count_at_ready", txn_count, it.cnt);
        end
      end
    end
  endtask

  // kind: 0 clean, 1 drop valid, 2 addr change, 4 wdata change, 5 instr change
  task automatic run_txn(input bit instr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int wr, input int kind);
    int   n, k, vpos, wcode;
    exp_t it;
    @(negedge clock);
    k     = cyc;
    n     = (wr > MAXW) ? MAXW : wr;
    vpos  = (n > 0) ? int'($urandom_range(1, n)) : 0;
    wcode = 0;
    if (n > 0) begin
      case (kind)
        1:       wcode = 1;
        2, 5:    wcode = 2;
        4:       wcode = (wstrb != 4'h0) ? 2 : 0;
        default: wcode = 0;
      endcase
    end
    if (m_err == 0 && !is_legal(addr, wstrb)) begin m_err = 1; m_code = 3; end
    if (m_err == 0 && wcode != 0) begin m_err = 1; m_code = wcode; end
    it.ready_cyc = k + n + 1;
    it.err       = m_err;
    it.code      = m_code;
    it.cnt       = m_cnt;
    sb.push_back(it);
    m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    for (int j = 1; j <= n + 1; j++) busy_map[k + j] = 1;
    drive(1, instr, addr, wdata, wstrb);
    wait_req = 3'(wr);
    for (int j = 1; j <= n + 1; j++) begin
      @(negedge clock);
      drive(1, instr, addr, wdata, wstrb);
      wait_req = 3'($urandom_range(0, 7));
      if (j == vpos) begin
        case (kind)
          1:       bus.mem_valid = 1'b0;
          2:       bus.mem_addr  = addr ^ 32'h4;
          4:       bus.mem_wdata = ~wdata;
          5:       bus.mem_instr = ~instr;
          default: ;
        endcase
      end
    end
  endtask

  task automatic idle(input int g);
    repeat (g) begin
      @(negedge clock);
      bus.mem_valid = 1'b0;
      wait_req = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, bus.mem_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, protocol_err, 0);
    check({tag, "_code"}, err_code, 0);
    check({tag, "_count"}, txn_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    mon_en = 0;
    bus.mem_valid = 1'b0;
    reset = 1'b1;
    #1 check_zero("reset");
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    m_err = 0; m_code = 0; m_cnt = 0;
    mon_en = 1;
  endtask

  task automatic seg_check(input string tag);
    check({tag, "_count"}, txn_count, m_cnt);
    check({tag, "_err"}, protocol_err, m_err);
    check({tag, "_code"}, err_code, m_code);
  endtask

  task automatic random_segment(input int ntx);
    bit          instr;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    int          r, kind;
    for (int t = 0; t < ntx; t++) begin
      instr = 1'($urandom_range(0, 1));
      addr  = $urandom() & 32'hFFFF_FFFC;
      wdata = $urandom();
      wstrb = instr ? 4'h0 : legal_strb[$urandom_range(0, 7)];
      r     = int'($urandom_range(0, 99));
      kind  = (r < 6) ? 1 : (r < 12) ? 2 : (r < 18) ? 4 : (r < 22) ? 5 : 0;
      if (r >= 22 && r < 26) begin
        if ($urandom_range(0, 1) == 1) addr[1:0] = 2'($urandom_range(1, 3));
        else wstrb = bad_strb[$urandom_range(0, 7)];
      end
      run_txn(instr, addr, wdata, wstrb, int'($urandom_range(0, 7)), kind);
      idle(int'($urandom_range(0, 2)));
    end
    idle(3);
  endtask

  initial begin
    drive(0, 0, 32'h0, 32'h0, 4'h0);
    fork
      run_monitor();
    join_none

    // Clean traffic: zero wait, three waits, clamped wait, benign read wdata change
    do_reset();
    run_txn(0, 32'h100, 32'h0, 4'h0, 0, 0);
    idle(1);
    run_txn(0, 32'h204, 32'hA5A5_A5A5, 4'hF, 3, 0);
    idle(1);
    run_txn(1, 32'h308, 32'h0, 4'h0, 7, 0);
    run_txn(0, 32'h180, 32'h1234, 4'h0, 2, 4);
    idle(2);
    seg_check("clean");

    do_reset();
    run_txn(0, 32'h100, 32'h0, 4'h0, 2, 2);
    idle(1);
    run_txn(0, 32'h108, 32'h0, 4'h0, 2, 1);
    idle(2);
    seg_check("payload_then_drop");

    do_reset();
    run_txn(0, 32'h102, 32'h11, 4'h5, 1, 0);
    idle(2);
    seg_check("illegal_both");

    do_reset();
    run_txn(0, 32'h200, 32'h55, 4'h6, 0, 0);
    idle(2);
    seg_check("illegal_wstrb");

    do_reset();
    run_txn(0, 32'h10, 32'h0, 4'h0, 3, 1);
    idle(2);
    seg_check("valid_drop");

    // Asynchronous reset in the middle of a long wait
    do_reset();
    run_txn(0, 32'h40, 32'h0, 4'h0, 1, 1);
    run_txn(0, 32'h44, 32'h0, 4'h0, 0, 0);
    idle(1);
    @(negedge clock);
    mon_en = 0;
    drive(1, 0, 32'h300, 32'h0, 4'h0);
    wait_req = 3'd5;
    @(negedge clock);
    @(negedge clock);
    check("busy_before_reset", busy, 1);
    check("count_before_reset", txn_count, m_cnt);
    check("err_before_reset", protocol_err, m_err);
    #2 reset = 1'b1;
    #1 check_zero("midwait_reset");
    @(negedge clock);
    reset = 1'b0;
    bus.mem_valid = 1'b0;
    sb.delete();
    m_err = 0; m_code = 0; m_cnt = 0;
    mon_en = 1;
    run_txn(1, 32'h400, 32'h0, 4'h0, 2, 0);
    idle(2);
    seg_check("after_reset");

    for (int s = 0; s < 3; s++) begin
      do_reset();
      random_segment(40);
      seg_check("random");
    end

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
